// File: rtl/sim_run_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sim_run_pkg                                                              |
// | Shared types and constants for the simulation run sequencer.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sim_run_pkg;

    localparam int SIM_CFG_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } sim_run_state_t;

    localparam logic [1:0] SIM_STATUS_NONE    = 2'd0;
    localparam logic [1:0] SIM_STATUS_PASS    = 2'd1;
    localparam logic [1:0] SIM_STATUS_FAIL    = 2'd2;
    localparam logic [1:0] SIM_STATUS_TIMEOUT = 2'd3;

    function automatic logic is_terminal(input sim_run_state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter                                                              |
// | Width-parameterised saturating up-counter with clear and enable.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    // Clear has priority over enable; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en && (o_count != '1)) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sim_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sim_run_controller                                                       |
// | Run sequencer: DUT reset window, run-cycle count, pass/fail/timeout.     |
// | Optional heartbeat enabled by defining SIM_RUN_HEARTBEAT_EN.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sim_run_controller
    import sim_run_pkg::*;
#(
    parameter int HB_LOG2 = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SIM_CFG_W-1:0] cfg_reset_hold,
    input  logic [SIM_CFG_W-1:0] cfg_max_cycles,
    input  logic                 dut_done,
    input  logic                 dut_fail,
    output logic                 dut_reset,
    output logic                 running,
    output logic                 finish,
    output logic [1:0]           status,
    output logic [SIM_CFG_W-1:0] cycle_count,
    output logic                 heartbeat
);

    sim_run_state_t       r_state;
    sim_run_state_t       w_next;
    logic [SIM_CFG_W-1:0] r_hold;
    logic [SIM_CFG_W-1:0] r_max;
    logic [SIM_CFG_W-1:0] w_hold_cnt;
    logic                 w_hold_last;
    logic                 w_timeout;
    logic                 w_hold_en;
    logic                 w_hold_clr;
    logic                 w_cyc_en;
    logic                 w_cyc_clr;

    always_comb begin
        w_hold_last = (w_hold_cnt == (r_hold - SIM_CFG_W'(1)));
        w_timeout   = (r_max != '0) && (cycle_count == (r_max - SIM_CFG_W'(1)));
        w_next      = r_state;
        case (r_state)
            ST_IDLE: if (start)       w_next = ST_HOLD;
            ST_HOLD: if (w_hold_last) w_next = ST_RUN;
            ST_RUN: begin
                if (dut_fail)       w_next = ST_FAIL;
                else if (dut_done)  w_next = ST_PASS;
                else if (w_timeout) w_next = ST_TIMEOUT;
            end
            default: w_next = r_state;
        endcase
    end

    // The count does not advance on a done/fail edge, but does on the timeout edge.
    assign w_hold_en  = (r_state == ST_HOLD);
    assign w_hold_clr = (r_state != ST_HOLD);
    assign w_cyc_en   = (r_state == ST_RUN) && !dut_fail && !dut_done;
    assign w_cyc_clr  = (r_state == ST_IDLE) || (r_state == ST_HOLD);

    sat_counter #(.WIDTH(SIM_CFG_W)) u_hold_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clr   (w_hold_clr),
        .i_en    (w_hold_en),
        .o_count (w_hold_cnt)
    );

    sat_counter #(.WIDTH(SIM_CFG_W)) u_cycle_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clr   (w_cyc_clr),
        .i_en    (w_cyc_en),
        .o_count (cycle_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_max     <= '0;
            dut_reset <= 1'b1;
            running   <= 1'b0;
            finish    <= 1'b0;
            status    <= SIM_STATUS_NONE;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && start) begin
                r_hold <= (cfg_reset_hold == '0) ? SIM_CFG_W'(1) : cfg_reset_hold;
                r_max  <= cfg_max_cycles;
            end
            dut_reset <= (w_next == ST_IDLE) || (w_next == ST_HOLD);
            running   <= (w_next == ST_RUN);
            finish    <= is_terminal(w_next) && !is_terminal(r_state);
            if (r_state == ST_RUN) begin
                case (w_next)
                    ST_PASS:    status <= SIM_STATUS_PASS;
                    ST_FAIL:    status <= SIM_STATUS_FAIL;
                    ST_TIMEOUT: status <= SIM_STATUS_TIMEOUT;
                    default:    status <= status;
                endcase
            end
        end
    end

`ifdef SIM_RUN_HEARTBEAT_EN
    logic [HB_LOG2-1:0] w_hb_low_next;
    logic               r_heartbeat;

    // Pulse alongside the count value whose low bits are all ones.
    assign w_hb_low_next = cycle_count[HB_LOG2-1:0] + HB_LOG2'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_heartbeat <= 1'b0;
        end else begin
            r_heartbeat <= w_cyc_en && (w_next == ST_RUN) && (&w_hb_low_next);
        end
    end

    assign heartbeat = r_heartbeat;
`else
    localparam logic c_hb_tie = (HB_LOG2 < 0);
    assign heartbeat = c_hb_tie;
`endif

endmodule
`default_nettype wire

// File: doc/sim_run_controller.md
# sim_run_controller

Simulation run sequencer that owns the DUT reset window, run-cycle accounting and pass/fail/timeout verdict for a test-harness top. Its runtime limits arrive as 32-bit configuration words, driven at harness level by plusarg readers (`+reset_hold=%d`, `+max_cycles=%d`) and latched when a run starts. It sits beside the accelerator DUT in the simulation top, and `finish` drives the harness `$finish` logic. Pure RTL (no system tasks), so it also runs on emulation/FPGA harnesses.

## Interface
- `HB_LOG2`, default 16: heartbeat period is 2^HB_LOG2 run cycles (used only with the heartbeat feature).
- `clock`  in  1  sole clock; all state is in this domain.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  level; begins a run when sampled high in IDLE.
- `cfg_reset_hold`  in  32  DUT reset cycles; 0 is treated as 1.
- `cfg_max_cycles`  in  32  RUN cycle limit; 0 disables timeout.
- `dut_done`  in  1  DUT reports success.
- `dut_fail`  in  1  DUT reports failure.
- `dut_reset`  out  1  reset to the DUT.
- `running`  out  1  high in RUN.
- `finish`  out  1  one-cycle pulse on entry to a terminal state.
- `status`  out  2  0 = none, 1 = pass, 2 = fail, 3 = timeout; sticky.
- `cycle_count`  out  32  RUN cycles elapsed; saturates at 0xFFFF_FFFF.
- `heartbeat`  out  1  periodic pulse (see Configuration).

## Operation
- States: IDLE, HOLD, RUN, PASS, FAIL, TIMEOUT.
- IDLE -> HOLD when `start`=1. On that edge, latch `cfg_reset_hold` (0 is forced to 1) and `cfg_max_cycles`. Config changes after the latch are ignored.
- HOLD: `dut_reset`=1. `hold_cnt` counts from 0. When `hold_cnt` == latched_hold-1, go to RUN. `dut_done`/`dut_fail` are ignored in HOLD.
- RUN: `dut_reset`=0, `running`=1, `cycle_count` increments every RUN cycle. Per-cycle priority:
  - `dut_fail` -> FAIL
  - else `dut_done` -> PASS
  - else if latched_max != 0 and `cycle_count` == latched_max-1 -> TIMEOUT
  - else stay in RUN.
- Terminal states PASS/FAIL/TIMEOUT:
  - Sticky until `reset`; `start` is ignored.
  - `dut_reset`=0, `running`=0.
  - `cycle_count` frozen.
- `status` is 0 in IDLE/HOLD/RUN and is set on the terminal edge.
- `finish` is high for exactly the first cycle in a terminal state.
- `reset` asserted mid-run: immediate return to IDLE with all outputs at their reset values. The latched config is cleared to 0.

## Timing
- Reset values: `dut_reset`=1, `running`=0, `finish`=0, `status`=0, `cycle_count`=0, `heartbeat`=0, state IDLE.
- All outputs are registered; no combinational input-to-output path.
- `start` sampled at edge T: HOLD from T+1. `dut_reset` stays high continuously from reset through HOLD.
- HOLD lasts exactly latched_hold cycles. RUN's first cycle has `running`=1, `dut_reset`=0, `cycle_count`=0.
- `dut_done`/`dut_fail` sampled high in RUN at edge T: terminal state, `status` and `finish` all visible after T. `cycle_count` then holds the number of RUN cycles before T, with no increment on the terminal edge.
- Timeout: with latched_max = N, TIMEOUT is entered after exactly N RUN cycles, and `cycle_count` = N.
- Done/fail in the same cycle as the timeout condition: done/fail wins.

## Configuration
- `SIM_RUN_HEARTBEAT_EN` defined: `heartbeat` pulses for one cycle whenever `cycle_count`[HB_LOG2-1:0] == all-ones while in RUN. It also pulses on the last cycle of each 2^HB_LOG2-cycle block.
- `SIM_RUN_HEARTBEAT_EN` undefined: `heartbeat` is tied to 0 and no heartbeat logic is generated.

## Structure
- Shared package `sim_run_pkg` holds:
  - state enum `sim_run_state_t`
  - status encoding constants `SIM_STATUS_NONE/PASS/FAIL/TIMEOUT`
  - `SIM_CFG_W` = 32.
- One sub-module, `sat_counter`: width-parameterised saturating up-counter with clear and enable. It is instantiated twice, for `hold_cnt` and `cycle_count`.
- Plusarg readers are instantiated in the harness top, not inside this block.

## Test plan
- Reset, then `start`=1 with hold=3, max=0; assert `dut_done` on RUN cycle 5 -> `dut_reset` high for 3 cycles after IDLE; PASS; `status`=1; `cycle_count`=5; `finish` high for 1 cycle.
- hold=0, max=10, no done -> HOLD lasts 1 cycle; TIMEOUT after 10 RUN cycles; `status`=3; `cycle_count`=10.
- max=10 with `dut_done`=1 and `dut_fail`=1 on RUN cycle 9 (the timeout cycle) -> FAIL; `status`=2; `cycle_count`=9.
- Change `cfg_max_cycles` from 10 to 3 during RUN -> timeout still at 10. `start` pulsed in PASS -> no state change.
- Assert `reset` on RUN cycle 4 -> next sampled cycle shows IDLE, `dut_reset`=1, `cycle_count`=0, `status`=0. A new run then behaves normally.
- With `SIM_RUN_HEARTBEAT_EN` and HB_LOG2=2, max=0, run 12 cycles -> `heartbeat` pulses when `cycle_count` = 3, 7, 11. Without the macro, `heartbeat` stays 0.
